// File: rtl/nibbler_pkg.sv
// Shared encodings for the Nibbler core: sequencer command codes and default
// program address width. Decode and the sequencer both import this package.
package nibbler_pkg;

  localparam int NIBBLER_AW = 12;

  localparam logic [2:0] CMD_HOLD  = 3'd0;
  localparam logic [2:0] CMD_INC   = 3'd1;
  localparam logic [2:0] CMD_JMP   = 3'd2;
  localparam logic [2:0] CMD_JCOND = 3'd3;
  localparam logic [2:0] CMD_CALL  = 3'd4;
  localparam logic [2:0] CMD_RET   = 3'd5;
  // Codes 6 and 7 are reserved and behave as CMD_HOLD.

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses: a register array plus a level counter.
// Entry[level] is written on push; entry[level-1] is the top and is removed on pop.
// Overflow/underflow policy belongs to the caller; push on full and pop on
// empty are simply ignored here so the stack can never corrupt itself.
module return_stack #(
  parameter int AW    = 12,
  parameter int DEPTH = 4,
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [AW-1:0] entry [DEPTH];

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  // Level counter: one push or one pop per cycle, push has priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level <= '0;
    end else if (push && !full) begin
      level <= level + LW'(1);
    end else if (pop && !empty) begin
      level <= level - LW'(1);
    end
  end

  // Entry storage: contents are don't-care after reset, so no reset term.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && !full && (level == LW'(i))) begin
        entry[i] <= push_data;
      end
    end
  end

  // Top-of-stack select; reads zero when empty (never consumed then).
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (level == LW'(i + 1)) begin
        top = entry[i];
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-address sequencer: registered pc, next-address mux, return stack
// and sticky overflow/underflow flags. pc_next is combinational so the ROM
// can prefetch; pc simply registers pc_next every cycle (pc_next == pc when
// enable is low, which gives the freeze behaviour for free).
module pc_sequencer
  import nibbler_pkg::*;
#(
  parameter int            AW         = NIBBLER_AW,
  parameter int            DEPTH      = 4,
  parameter logic [AW-1:0] RESET_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [2:0]                 cmd,
  input  logic                       cond,
  input  logic [AW-1:0]              target,
  input  logic                       clr_err,
  output logic [AW-1:0]              pc,
  output logic [AW-1:0]              pc_next,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf,
  output logic                       unf
);

  logic [AW-1:0] pc_inc;
  logic [AW-1:0] stack_top;
  logic          push;
  logic          pop;
  logic          ovf_evt;
  logic          unf_evt;

  // Wraps modulo 2^AW; also the value pushed as the return address.
  assign pc_inc = pc + AW'(1);

  return_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_return_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (stack_top),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  // Next-address mux and stack/error decisions for the current command.
  always_comb begin
    pc_next = pc;
    push    = 1'b0;
    pop     = 1'b0;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    if (enable) begin
      case (cmd)
        CMD_INC:   pc_next = pc_inc;
        CMD_JMP:   pc_next = target;
        CMD_JCOND: pc_next = cond ? target : pc_inc;
        CMD_CALL: begin
          if (!full) begin
            push    = 1'b1;
            pc_next = target;
          end else begin
            ovf_evt = 1'b1;
            pc_next = pc_inc;
          end
        end
        CMD_RET: begin
          if (!empty) begin
            pop     = 1'b1;
            pc_next = stack_top;
          end else begin
            unf_evt = 1'b1;
            pc_next = pc_inc;
          end
        end
        default:   pc_next = pc;
      endcase
    end
  end

  // Program address register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_ADDR;
    end else begin
      pc <= pc_next;
    end
  end

  // Sticky error flags: a new event wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      ovf <= ovf_evt | (ovf & ~clr_err);
      unf <= unf_evt | (unf & ~clr_err);
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed sequences with literal expectations, then
// randomized commands checked every cycle against a queue-based model.
module tb_pc_sequencer;
  import nibbler_pkg::*;

  localparam int            AW     = 12;
  localparam int            DEPTH  = 4;
  localparam int            LW     = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] RST_PC = 12'h000;

  // ---------------- clock / reset ----------------
  logic          clk     = 1'b0;
  logic          reset   = 1'b1;
  logic          enable  = 1'b0;
  logic [2:0]    cmd     = 3'd0;
  logic          cond    = 1'b0;
  logic [AW-1:0] target  = '0;
  logic          clr_err = 1'b0;

  logic [AW-1:0] pc;
  logic [AW-1:0] pc_next;
  logic [LW-1:0] level;
  logic          full;
  logic          empty;
  logic          ovf;
  logic          unf;

  always #5 clk = ~clk;

  pc_sequencer #(
    .AW         (AW),
    .DEPTH      (DEPTH),
    .RESET_ADDR (RST_PC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .cmd     (cmd),
    .cond    (cond),
    .target  (target),
    .clr_err (clr_err),
    .pc      (pc),
    .pc_next (pc_next),
    .level   (level),
    .full    (full),
    .empty   (empty),
    .ovf     (ovf),
    .unf     (unf)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // exp_q holds the expected return-stack contents, back = top of stack.
  logic [AW-1:0] m_pc;
  logic [AW-1:0] exp_q[$];
  bit            m_ovf;
  bit            m_unf;

  function automatic logic [AW-1:0] model_next();
    logic [AW-1:0] inc;
    inc = m_pc + AW'(1);
    if (!enable) return m_pc;
    case (cmd)
      3'd1:    return inc;
      3'd2:    return target;
      3'd3:    return cond ? target : inc;
      3'd4:    return (exp_q.size() < DEPTH) ? target : inc;
      3'd5:    return (exp_q.size() > 0) ? exp_q[$] : inc;
      default: return m_pc;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc  = RST_PC;
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin : model_step
      logic [AW-1:0] nxt;
      bit ovf_ev;
      bit unf_ev;
      nxt    = model_next();
      ovf_ev = enable && (cmd == 3'd4) && (exp_q.size() == DEPTH);
      unf_ev = enable && (cmd == 3'd5) && (exp_q.size() == 0);
      if (enable && (cmd == 3'd4) && !ovf_ev) exp_q.push_back(m_pc + AW'(1));
      if (enable && (cmd == 3'd5) && !unf_ev) void'(exp_q.pop_back());
      m_ovf = ovf_ev || (m_ovf && !clr_err);
      m_unf = unf_ev || (m_unf && !clr_err);
      m_pc  = nxt;
    end
  end

  // Compare process: every cycle on the falling edge, inputs are stable.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc pc",      32'(pc),      32'(m_pc));
      check("cyc pc_next", 32'(pc_next), 32'(model_next()));
      check("cyc level",   32'(level),   32'(exp_q.size()));
      check("cyc full",    32'(full),    32'(exp_q.size() == DEPTH));
      check("cyc empty",   32'(empty),   32'(exp_q.size() == 0));
      check("cyc ovf",     32'(ovf),     32'(m_ovf));
      check("cyc unf",     32'(unf),     32'(m_unf));
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; drives one cycle and returns 1 after the next edge.
  task automatic op(input bit en, input logic [2:0] c, input bit cd,
                    input logic [AW-1:0] t, input bit clr);
    enable  = en;
    cmd     = c;
    cond    = cd;
    target  = t;
    clr_err = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic op_chk(input string name, input bit en, input logic [2:0] c, input bit cd,
                        input logic [AW-1:0] t, input bit clr,
                        input logic [AW-1:0] exp_pc, input int exp_lvl);
    op(en, c, cd, t, clr);
    check({name, " pc"},    32'(pc),    32'(exp_pc));
    check({name, " level"}, 32'(level), 32'(exp_lvl));
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset pc",    32'(pc),    32'h000);
    check("reset level", 32'(level), 32'd0);
    check("reset empty", 32'(empty), 32'd1);
    check("reset full",  32'(full),  32'd0);
    check("reset ovf",   32'(ovf),   32'd0);
    check("reset unf",   32'(unf),   32'd0);
    reset  = 1'b1;
    chk_en = 1'b1;

    op_chk("inc1", 1, CMD_INC, 0, 12'h000, 0, 12'h001, 0);
    op_chk("inc2", 1, CMD_INC, 0, 12'h000, 0, 12'h002, 0);
    op_chk("inc3", 1, CMD_INC, 0, 12'h000, 0, 12'h003, 0);
    op_chk("call_pre_rst", 1, CMD_CALL, 0, 12'h040, 0, 12'h040, 1);

    // Asynchronous reset mid-run, observed before any clock edge.
    reset = 1'b0;
    #2;
    check("async_rst pc",    32'(pc),    32'h000);
    check("async_rst level", 32'(level), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    op_chk("jmp_fff",  1, CMD_JMP,   0, 12'hFFF, 0, 12'hFFF, 0);
    op_chk("inc_wrap", 1, CMD_INC,   0, 12'h123, 0, 12'h000, 0);
    op_chk("jmp_7a3",  1, CMD_JMP,   1, 12'h7A3, 0, 12'h7A3, 0);
    op_chk("jc_0",     1, CMD_JCOND, 0, 12'h555, 0, 12'h7A4, 0);
    op_chk("jc_1",     1, CMD_JCOND, 1, 12'h010, 0, 12'h010, 0);
    op_chk("jmp_020",  1, CMD_JMP,   0, 12'h020, 0, 12'h020, 0);
    op_chk("call_100", 1, CMD_CALL,  0, 12'h100, 0, 12'h100, 1);
    op_chk("call_200", 1, CMD_CALL,  1, 12'h200, 0, 12'h200, 2);
    op_chk("ret_a",    1, CMD_RET,   0, 12'h999, 0, 12'h101, 1);
    op_chk("ret_b",    1, CMD_RET,   1, 12'h888, 0, 12'h021, 0);

    // Overflow: pushes 022, 301, 311, 321; fifth CALL falls through to pc+1.
    op_chk("ov_c1", 1, CMD_CALL, 0, 12'h300, 0, 12'h300, 1);
    op_chk("ov_c2", 1, CMD_CALL, 0, 12'h310, 0, 12'h310, 2);
    op_chk("ov_c3", 1, CMD_CALL, 0, 12'h320, 0, 12'h320, 3);
    op_chk("ov_c4", 1, CMD_CALL, 0, 12'h330, 0, 12'h330, 4);
    check("ov_c4 ovf", 32'(ovf), 32'd0);
    op_chk("ov_c5", 1, CMD_CALL, 0, 12'h340, 0, 12'h331, 4);
    check("ov_c5 ovf",  32'(ovf),  32'd1);
    check("ov_c5 full", 32'(full), 32'd1);
    op_chk("un_r1", 1, CMD_RET, 0, 12'h000, 0, 12'h321, 3);
    op_chk("un_r2", 1, CMD_RET, 0, 12'h000, 0, 12'h311, 2);
    op_chk("un_r3", 1, CMD_RET, 0, 12'h000, 0, 12'h301, 1);
    op_chk("un_r4", 1, CMD_RET, 0, 12'h000, 0, 12'h022, 0);
    check("un_r4 unf", 32'(unf), 32'd0);
    op_chk("un_r5", 1, CMD_RET, 0, 12'h000, 0, 12'h023, 0);
    check("un_r5 unf",   32'(unf),   32'd1);
    check("un_r5 ovf",   32'(ovf),   32'd1);
    check("un_r5 empty", 32'(empty), 32'd1);

    // clr_err alone clears both flags.
    op_chk("clr", 0, CMD_HOLD, 0, 12'h000, 1, 12'h023, 0);
    check("clr ovf", 32'(ovf), 32'd0);
    check("clr unf", 32'(unf), 32'd0);

    // Overflow concurrent with clr_err keeps ovf set.
    op_chk("f_c1", 1, CMD_CALL, 0, 12'h400, 0, 12'h400, 1);
    op_chk("f_c2", 1, CMD_CALL, 0, 12'h410, 0, 12'h410, 2);
    op_chk("f_c3", 1, CMD_CALL, 0, 12'h420, 0, 12'h420, 3);
    op_chk("f_c4", 1, CMD_CALL, 0, 12'h430, 0, 12'h430, 4);
    op_chk("ovf_clr", 1, CMD_CALL, 0, 12'h440, 1, 12'h431, 4);
    check("ovf_clr ovf", 32'(ovf), 32'd1);
    op_chk("clr2", 0, CMD_RET, 0, 12'h000, 1, 12'h431, 4);
    check("clr2 ovf", 32'(ovf), 32'd0);

    // Enable low freezes everything, pc_next follows pc.
    for (int i = 0; i < 5; i++) begin
      op_chk("frozen", 0, CMD_CALL, 1, 12'h777, 0, 12'h431, 4);
    end
    check("frozen pc_next", 32'(pc_next), 32'h431);
    check("frozen ovf",     32'(ovf),     32'd0);

    // Reserved codes hold.
    op_chk("rsv6", 1, 3'd6, 1, 12'h555, 0, 12'h431, 4);
    op_chk("rsv7", 1, 3'd7, 1, 12'h555, 0, 12'h431, 4);

    // Drain: pushes were 024, 401, 411, 421.
    op_chk("d_r1", 1, CMD_RET, 0, 12'h000, 0, 12'h421, 3);
    op_chk("d_r2", 1, CMD_RET, 0, 12'h000, 0, 12'h411, 2);
    op_chk("d_r3", 1, CMD_RET, 0, 12'h000, 0, 12'h401, 1);
    op_chk("d_r4", 1, CMD_RET, 0, 12'h000, 0, 12'h024, 0);

    // Return address wraps when calling from all-ones.
    op_chk("w_jmp",  1, CMD_JMP,  0, 12'hFFF, 0, 12'hFFF, 0);
    op_chk("w_call", 1, CMD_CALL, 0, 12'h050, 0, 12'h050, 1);
    op_chk("w_ret",  1, CMD_RET,  0, 12'h000, 0, 12'h000, 0);

    // Randomized commands, checked each cycle by the compare process.
    for (int i = 0; i < 600; i++) begin
      int          r;
      logic [2:0]  c;
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1:    c = CMD_INC;
        2:       c = CMD_JMP;
        3:       c = CMD_JCOND;
        4, 5:    c = CMD_CALL;
        6, 7:    c = CMD_RET;
        8:       c = CMD_HOLD;
        default: c = 3'($urandom_range(6, 7));
      endcase
      op($urandom_range(0, 7) != 0, c, 1'($urandom_range(0, 1)),
         AW'($urandom_range(0, 4095)), $urandom_range(0, 15) == 0);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
